// File: rtl/vend_txn_ctrl.sv
// vend_txn_ctrl
//   Vending transaction controller. One FSM owns the whole transaction:
//   it collects money into a credit register and validates a product
//   selection against a writable price table. It then handshakes the
//   dispense and pays out change one coin per handshake from a tracked
//   coin inventory.
//
//   Optional feature (macro VEND_TIMEOUT_EN): an inactivity timer in
//   COLLECT. After TIMEOUT_CYCLES cycles without an accepted input, the
//   block behaves exactly as if cancel had been asserted. When the macro
//   is undefined there is no timer and COLLECT waits indefinitely.
//
// Ports
//   clock, reset                  system clock, synchronous active-low reset
//   money_valid/type/ready        one-hot denomination input handshake
//   select_valid/addr/ready       product selection handshake
//   cancel                        abort the transaction and refund credit
//   price_we/waddr/wdata          price table write port (applied in IDLE only)
//   dispense_valid/addr/ready     dispenser request handshake
//   change_valid/coin/ready       change hopper handshake, one coin at a time
//   credit                        current credit
//   num_500..num_5000             coin inventory counts
//   error                         last error code (sticky until a success)
//   state                         FSM state, for debug
//
// FSM states
//   state   | meaning
//   IDLE    | no credit; price table writable; first money starts a transaction
//   COLLECT | credit held; accepts money, selection or cancel
//   VEND    | dispense_valid held until the dispenser takes it
//   CHANGE  | paying out credit, largest coin available first
module vend_txn_ctrl #(
  parameter int CREDIT_W       = 16,
  parameter int NUM_PRODUCTS   = 8,
  parameter int ADDR_W         = 3,
  parameter int CNT_W          = 8,
  parameter int MAX_CREDIT     = 20000,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                money_valid,
  input  logic [3:0]          money_type,
  output logic                money_ready,
  input  logic                select_valid,
  input  logic [ADDR_W-1:0]   select_addr,
  output logic                select_ready,
  input  logic                cancel,
  input  logic                price_we,
  input  logic [ADDR_W-1:0]   price_waddr,
  input  logic [CREDIT_W-1:0] price_wdata,
  output logic                dispense_valid,
  output logic [ADDR_W-1:0]   dispense_addr,
  input  logic                dispense_ready,
  output logic                change_valid,
  output logic [3:0]          change_coin,
  input  logic                change_ready,
  output logic [CREDIT_W-1:0] credit,
  output logic [CNT_W-1:0]    num_500,
  output logic [CNT_W-1:0]    num_1000,
  output logic [CNT_W-1:0]    num_2000,
  output logic [CNT_W-1:0]    num_5000,
  output logic [3:0]          error,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_VEND    = 3'd2,
    S_CHANGE  = 3'd3
  } state_t;

  localparam logic [3:0] ERR_NONE          = 4'd0;
  localparam logic [3:0] ERR_INVALID_MONEY = 4'd1;
  localparam logic [3:0] ERR_INSUFFICIENT  = 4'd2;
  localparam logic [3:0] ERR_OVERFLOW      = 4'd3;
  localparam logic [3:0] ERR_NO_CHANGE     = 4'd4;
  localparam logic [3:0] ERR_BAD_ADDR      = 4'd5;
  localparam logic [3:0] ERR_COIN_FULL     = 4'd6;

  localparam logic [CREDIT_W-1:0] V500  = CREDIT_W'(500);
  localparam logic [CREDIT_W-1:0] V1000 = CREDIT_W'(1000);
  localparam logic [CREDIT_W-1:0] V2000 = CREDIT_W'(2000);
  localparam logic [CREDIT_W-1:0] V5000 = CREDIT_W'(5000);
  localparam logic [CREDIT_W:0]   MAX_C = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [ADDR_W:0]     NUM_P = (ADDR_W+1)'(NUM_PRODUCTS);

  function automatic logic [CREDIT_W-1:0] coin_value(input logic [3:0] oh);
    logic [CREDIT_W-1:0] v;
    v = '0;
    case (oh)
      4'b0001: v = V500;
      4'b0010: v = V1000;
      4'b0100: v = V2000;
      4'b1000: v = V5000;
      default: v = '0;
    endcase
    return v;
  endfunction

  state_t              state_q;
  logic [CREDIT_W-1:0] price_tbl [NUM_PRODUCTS];

  logic                money_fire;
  logic                select_fire;
  logic                cancel_fire;
  logic                timeout_hit;
  logic                abort;
  logic [CREDIT_W-1:0] money_val;
  logic [CREDIT_W:0]   money_sum;
  logic                money_onehot;
  logic                money_full;
  logic                addr_ok;
  logic [CREDIT_W-1:0] sel_price;
  logic [3:0]          chg_pick;

  assign state = state_q;

  // Cancel blocks money, and money blocks selection, giving the
  // cancel > money > select priority at the handshake itself.
  assign money_ready  = (state_q == S_IDLE || state_q == S_COLLECT) && !cancel;
  assign select_ready = (state_q == S_COLLECT) && !money_valid && !cancel;

  assign money_fire  = money_valid && money_ready;
  assign select_fire = select_valid && select_ready;
  assign cancel_fire = cancel && (state_q == S_COLLECT);
  assign abort       = cancel_fire || timeout_hit;

  assign money_onehot = $onehot(money_type);
  assign money_val    = coin_value(money_type);
  // One extra bit so credit + value cannot wrap before the limit compare.
  assign money_sum    = {1'b0, credit} + {1'b0, money_val};

  always_comb begin
    money_full = 1'b0;
    case (money_type)
      4'b0001: money_full = &num_500;
      4'b0010: money_full = &num_1000;
      4'b0100: money_full = &num_2000;
      4'b1000: money_full = &num_5000;
      default: money_full = 1'b0;
    endcase
  end

  assign addr_ok   = {1'b0, select_addr} < NUM_P;
  assign sel_price = addr_ok ? price_tbl[select_addr] : '0;

  // Greedy change: largest coin that fits in the credit and is in stock.
  always_comb begin
    chg_pick = 4'b0000;
    if (credit >= V5000 && num_5000 != '0)
      chg_pick = 4'b1000;
    else if (credit >= V2000 && num_2000 != '0)
      chg_pick = 4'b0100;
    else if (credit >= V1000 && num_1000 != '0)
      chg_pick = 4'b0010;
    else if (credit >= V500 && num_500 != '0)
      chg_pick = 4'b0001;
  end

`ifdef VEND_TIMEOUT_EN
  localparam logic [CREDIT_W-1:0] TMR_LOAD = CREDIT_W'(TIMEOUT_CYCLES - 1);
  logic [CREDIT_W-1:0] tmr_q;

  // Down-counter parked at its load value outside COLLECT, so entering
  // COLLECT always starts a full window. Terminal count fires the abort.
  assign timeout_hit = (state_q == S_COLLECT) && !money_fire && !select_fire &&
                       (tmr_q == '0);

  always_ff @(posedge clock) begin
    if (!reset) begin
      tmr_q <= TMR_LOAD;
    end else if (state_q != S_COLLECT || money_fire || select_fire) begin
      tmr_q <= TMR_LOAD;
    end else if (tmr_q != '0) begin
      tmr_q <= tmr_q - 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      credit         <= '0;
      num_500        <= '0;
      num_1000       <= '0;
      num_2000       <= '0;
      num_5000       <= '0;
      error          <= ERR_NONE;
      dispense_valid <= 1'b0;
      dispense_addr  <= '0;
      change_valid   <= 1'b0;
      change_coin    <= 4'b0000;
      for (int i = 0; i < NUM_PRODUCTS; i++)
        price_tbl[i] <= CREDIT_W'(500 * (i + 1));
    end else begin
      if (price_we && state_q == S_IDLE && ({1'b0, price_waddr} < NUM_P))
        price_tbl[price_waddr] <= price_wdata;

      case (state_q)
        S_IDLE, S_COLLECT: begin
          if (abort) begin
            state_q <= S_CHANGE;
          end else if (money_fire) begin
            if (!money_onehot) begin
              error <= ERR_INVALID_MONEY;
            end else if (money_sum > MAX_C) begin
              error <= ERR_OVERFLOW;
            end else if (money_full) begin
              error <= ERR_COIN_FULL;
            end else begin
              credit  <= money_sum[CREDIT_W-1:0];
              error   <= ERR_NONE;
              state_q <= S_COLLECT;
              case (money_type)
                4'b0001: num_500  <= num_500 + 1'b1;
                4'b0010: num_1000 <= num_1000 + 1'b1;
                4'b0100: num_2000 <= num_2000 + 1'b1;
                4'b1000: num_5000 <= num_5000 + 1'b1;
                default: ;
              endcase
            end
          end else if (select_fire) begin
            if (!addr_ok) begin
              error <= ERR_BAD_ADDR;
            end else if (sel_price > credit) begin
              error <= ERR_INSUFFICIENT;
            end else begin
              credit         <= credit - sel_price;
              dispense_addr  <= select_addr;
              dispense_valid <= 1'b1;
              error          <= ERR_NONE;
              state_q        <= S_VEND;
            end
          end
        end

        S_VEND: begin
          if (dispense_valid && dispense_ready) begin
            dispense_valid <= 1'b0;
            state_q        <= (credit != '0) ? S_CHANGE : S_IDLE;
          end
        end

        S_CHANGE: begin
          // A coin is offered, taken, then the next one is chosen from the
          // updated credit and inventory on the following cycle.
          if (change_valid) begin
            if (change_ready) begin
              change_valid <= 1'b0;
              credit       <= credit - coin_value(change_coin);
              case (change_coin)
                4'b0001: num_500  <= num_500 - 1'b1;
                4'b0010: num_1000 <= num_1000 - 1'b1;
                4'b0100: num_2000 <= num_2000 - 1'b1;
                4'b1000: num_5000 <= num_5000 - 1'b1;
                default: ;
              endcase
            end
          end else if (credit == '0) begin
            state_q <= S_IDLE;
          end else if (chg_pick != 4'b0000) begin
            change_valid <= 1'b1;
            change_coin  <= chg_pick;
          end else begin
            // Unpayable remainder stays as credit for the customer to use.
            error   <= ERR_NO_CHANGE;
            state_q <= S_COLLECT;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_txn_ctrl.sv
module tb_vend_txn_ctrl;

  localparam int K_INS  = 0;
  localparam int K_SEL  = 1;
  localparam int K_CAN  = 2;
  localparam int K_PW   = 3;
  localparam int K_CANM = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        money_valid = 1'b0;
  logic [3:0]  money_type = 4'b0;
  logic        money_ready;
  logic        select_valid = 1'b0;
  logic [2:0]  select_addr = 3'b0;
  logic        select_ready;
  logic        cancel = 1'b0;
  logic        price_we = 1'b0;
  logic [2:0]  price_waddr = 3'b0;
  logic [15:0] price_wdata = 16'b0;
  logic        dispense_valid;
  logic [2:0]  dispense_addr;
  logic        dispense_ready = 1'b0;
  logic        change_valid;
  logic [3:0]  change_coin;
  logic        change_ready = 1'b0;
  logic [15:0] credit;
  logic [7:0]  num_500, num_1000, num_2000, num_5000;
  logic [3:0]  error;
  logic [2:0]  state;

  vend_txn_ctrl #(.TIMEOUT_CYCLES(10)) dut (
    .clock(clock), .reset(reset),
    .money_valid(money_valid), .money_type(money_type), .money_ready(money_ready),
    .select_valid(select_valid), .select_addr(select_addr), .select_ready(select_ready),
    .cancel(cancel),
    .price_we(price_we), .price_waddr(price_waddr), .price_wdata(price_wdata),
    .dispense_valid(dispense_valid), .dispense_addr(dispense_addr), .dispense_ready(dispense_ready),
    .change_valid(change_valid), .change_coin(change_coin), .change_ready(change_ready),
    .credit(credit),
    .num_500(num_500), .num_1000(num_1000), .num_2000(num_2000), .num_5000(num_5000),
    .error(error), .state(state)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: transaction-level, plain arithmetic.
  int VAL [4] = '{500, 1000, 2000, 5000};
  int m_credit;
  int m_num [4];
  int m_price [8];
  int m_err;
  int m_st;           // 0 idle, 1 collecting (quiescent states only)
  int m_coins [$];
  bit m_vend;
  int m_disp_addr;

  task automatic m_reset();
    m_credit = 0; m_err = 0; m_st = 0; m_vend = 0;
    for (int i = 0; i < 4; i++) m_num[i] = 0;
    for (int i = 0; i < 8; i++) m_price[i] = 500 * (i + 1);
    m_coins.delete();
  endtask

  task automatic m_refund();
    while (m_credit > 0) begin
      int k;
      k = -1;
      for (int i = 3; i >= 0; i--)
        if (k < 0 && VAL[i] <= m_credit && m_num[i] > 0) k = i;
      if (k < 0) begin
        m_err = 4;
        m_st = 1;
        return;
      end
      m_coins.push_back(1 << k);
      m_credit -= VAL[k];
      m_num[k]--;
    end
    m_st = 0;
  endtask

  task automatic m_insert(input int t);
    int k;
    if ($countones(t[3:0]) != 1) begin
      m_err = 1;
      return;
    end
    k = 0;
    for (int i = 0; i < 4; i++) if (t[i]) k = i;
    if (m_credit + VAL[k] > 20000) m_err = 3;
    else if (m_num[k] == 255) m_err = 6;
    else begin
      m_credit += VAL[k];
      m_num[k]++;
      m_err = 0;
      m_st = 1;
    end
  endtask

  task automatic m_select(input int a);
    if (m_st != 1) return;
    if (a >= 8) m_err = 5;
    else if (m_price[a] > m_credit) m_err = 2;
    else begin
      m_credit -= m_price[a];
      m_err = 0;
      m_vend = 1;
      m_disp_addr = a;
      if (m_credit > 0) m_refund();
      else m_st = 0;
    end
  endtask

  // Observations gathered while servicing dispense/change handshakes.
  int got_coins [$];
  bit disp_seen;
  int disp_first;
  int disp_held;
  bit disp_unstable;
  bit coin_unstable;

  task automatic service(input int dly, input int cdly);
    bit done;
    int cw;
    logic [3:0] cur;
    done = 0; cw = 0; cur = 4'b0;
    got_coins.delete();
    disp_seen = 0; disp_first = 0; disp_held = 0;
    disp_unstable = 0; coin_unstable = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      dispense_ready = 1'b0;
      change_ready = 1'b0;
      if ((state == 3'd0 || state == 3'd1) && !dispense_valid && !change_valid) begin
        done = 1;
        break;
      end
      if (dispense_valid) begin
        if (!disp_seen) disp_first = dispense_addr;
        else if (dispense_addr != disp_first[2:0]) disp_unstable = 1;
        disp_seen = 1;
        disp_held++;
        if (disp_held > dly) dispense_ready = 1'b1;
      end
      if (change_valid) begin
        if (cw == 0) cur = change_coin;
        else if (change_coin !== cur) coin_unstable = 1;
        cw++;
        if (cw > cdly) begin
          got_coins.push_back(int'(change_coin));
          change_ready = 1'b1;
          cw = 0;
        end
      end
      @(negedge clock);
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL service_bound: transaction did not settle, state %0d", state);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " credit"}, credit, m_credit);
    chk({tag, " num_500"}, num_500, m_num[0]);
    chk({tag, " num_1000"}, num_1000, m_num[1]);
    chk({tag, " num_2000"}, num_2000, m_num[2]);
    chk({tag, " num_5000"}, num_5000, m_num[3]);
    chk({tag, " error"}, error, m_err);
    chk({tag, " state"}, state, m_st);
  endtask

  task automatic do_op(input string tag, input int kind, input int a, input int d, input int dly);
    m_coins.delete();
    m_vend = 0;
    @(negedge clock);
    case (kind)
      K_INS:  begin money_valid = 1'b1; money_type = a[3:0]; end
      K_SEL:  begin select_valid = 1'b1; select_addr = a[2:0]; end
      K_CAN:  cancel = 1'b1;
      K_PW:   begin price_we = 1'b1; price_waddr = a[2:0]; price_wdata = d[15:0]; end
      K_CANM: begin cancel = 1'b1; money_valid = 1'b1; money_type = 4'b0001; end
      default: ;
    endcase
    @(negedge clock);
    money_valid = 1'b0; select_valid = 1'b0; cancel = 1'b0; price_we = 1'b0;
    case (kind)
      K_INS:  m_insert(a);
      K_SEL:  m_select(a);
      K_CAN, K_CANM: if (m_st == 1) m_refund();
      K_PW:   if (m_st == 0) m_price[a] = d;
      default: ;
    endcase
    service(dly, dly & 1);
    check_model(tag);
    chk({tag, " coin_count"}, got_coins.size(), m_coins.size());
    for (int i = 0; i < m_coins.size() && i < got_coins.size(); i++)
      chk({tag, " coin"}, got_coins[i], m_coins[i]);
    chk({tag, " vend"}, disp_seen, m_vend);
    if (m_vend && disp_seen) begin
      chk({tag, " disp_addr"}, disp_first, m_disp_addr);
      chk({tag, " disp_held"}, disp_held, dly + 1);
      chk({tag, " disp_stable"}, disp_unstable, 0);
    end
    if (got_coins.size() > 0) chk({tag, " coin_stable"}, coin_unstable, 0);
  endtask

  typedef struct {
    int kind; int a; int d; int dly;
    int credit; int err; int st;
  } vec_t;

  vec_t tbl [25];

  task automatic reset_dut();
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    m_reset();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{K_INS,  1, 0, 0,   500, 0, 1};
    tbl[1]  = '{K_INS,  2, 0, 0,  1500, 0, 1};
    tbl[2]  = '{K_INS,  4, 0, 0,  3500, 0, 1};
    tbl[3]  = '{K_INS,  8, 0, 0,  8500, 0, 1};
    tbl[4]  = '{K_SEL,  3, 0, 3,     0, 0, 0};
    tbl[5]  = '{K_INS,  2, 0, 0,  1000, 0, 1};
    tbl[6]  = '{K_SEL,  7, 0, 0,  1000, 2, 1};
    tbl[7]  = '{K_INS,  6, 0, 0,  1000, 1, 1};
    tbl[8]  = '{K_CAN,  0, 0, 0,     0, 1, 0};
    tbl[9]  = '{K_PW,   0, 1500, 0,  0, 1, 0};
    tbl[10] = '{K_INS,  4, 0, 0,  2000, 0, 1};
    tbl[11] = '{K_SEL,  0, 0, 0,   500, 4, 1};
    tbl[12] = '{K_INS,  8, 0, 0,  5500, 0, 1};
    tbl[13] = '{K_INS,  8, 0, 0, 10500, 0, 1};
    tbl[14] = '{K_INS,  8, 0, 0, 15500, 0, 1};
    tbl[15] = '{K_INS,  4, 0, 0, 17500, 0, 1};
    tbl[16] = '{K_INS,  1, 0, 0, 18000, 0, 1};
    tbl[17] = '{K_INS,  8, 0, 0, 18000, 3, 1};
    tbl[18] = '{K_CANM, 0, 0, 1,   500, 4, 1};
    tbl[19] = '{K_SEL,  0, 0, 0,   500, 2, 1};
    tbl[20] = '{K_PW,   1, 100, 0, 500, 2, 1};
    tbl[21] = '{K_SEL,  1, 0, 0,   500, 2, 1};
    tbl[22] = '{K_INS,  1, 0, 0,  1000, 0, 1};
    tbl[23] = '{K_SEL,  1, 0, 2,     0, 0, 0};
    tbl[24] = '{K_INS,  1, 0, 0,   500, 0, 1};

    // Reset state, observed while reset is still held.
    m_reset();
    repeat (2) @(negedge clock);
    chk("rst credit", credit, 0);
    chk("rst num_500", num_500, 0);
    chk("rst num_5000", num_5000, 0);
    chk("rst error", error, 0);
    chk("rst state", state, 0);
    chk("rst dispense_valid", dispense_valid, 0);
    chk("rst change_valid", change_valid, 0);
    chk("rst change_coin", change_coin, 0);
    chk("rst dispense_addr", dispense_addr, 0);
    reset = 1'b1;
    @(negedge clock);
    chk("idle money_ready", money_ready, 1);
    chk("idle select_ready", select_ready, 0);

    for (int i = 0; i < 25; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      do_op(tag, tbl[i].kind, tbl[i].a, tbl[i].d, tbl[i].dly);
      chk({tag, " tbl_credit"}, credit, tbl[i].credit);
      chk({tag, " tbl_error"}, error, tbl[i].err);
      chk({tag, " tbl_state"}, state, tbl[i].st);
    end

    // Ready gating in COLLECT: money masks select, cancel masks both.
    money_valid = 1'b1; money_type = 4'b0001;
    #1;
    chk("collect select_ready w/ money", select_ready, 0);
    chk("collect money_ready", money_ready, 1);
    cancel = 1'b1;
    #1;
    chk("collect money_ready w/ cancel", money_ready, 0);
    money_valid = 1'b0; cancel = 1'b0;
    #1;
    chk("collect select_ready idle", select_ready, 1);

    // Randomized transactions against the model.
    for (int n = 0; n < 300; n++) begin
      int r, a, d, dly;
      r = $urandom_range(0, 9);
      dly = $urandom_range(0, 3);
      d = 0;
      case (r)
        0, 1, 2, 3, 9: begin
          if ($urandom_range(0, 4) == 0) a = $urandom_range(0, 15);
          else a = 1 << $urandom_range(0, 3);
          do_op("rnd_ins", K_INS, a, 0, dly);
        end
        4, 5: do_op("rnd_sel", K_SEL, $urandom_range(0, 7), 0, dly);
        6: do_op("rnd_can", K_CAN, 0, 0, dly);
        7: begin
          a = $urandom_range(0, 7);
          d = $urandom_range(1, 40) * 250;
          do_op("rnd_pw", K_PW, a, d, dly);
        end
        default: do_op("rnd_canm", K_CANM, 0, 0, dly);
      endcase
    end

    // Reset in the middle of a pending dispense.
    reset_dut();
    @(negedge clock);
    money_valid = 1'b1; money_type = 4'b0010;
    @(negedge clock);
    money_valid = 1'b0;
    select_valid = 1'b1; select_addr = 3'd0;
    @(negedge clock);
    select_valid = 1'b0;
    chk("midrst dispense_valid", dispense_valid, 1);
    chk("midrst default price", credit, 500);
    repeat (2) @(negedge clock);
    chk("midrst held", dispense_valid, 1);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    chk("midrst dispense_dropped", dispense_valid, 0);
    chk("midrst credit", credit, 0);
    chk("midrst state", state, 0);
    chk("midrst num_1000", num_1000, 0);

`ifdef VEND_TIMEOUT_EN
    do_op("tmo_ins", K_INS, 1, 0, 0);
    repeat (12) @(negedge clock);
    service(0, 0);
    chk("tmo coins", got_coins.size(), 1);
    if (got_coins.size() > 0) chk("tmo coin", got_coins[0], 1);
    chk("tmo credit", credit, 0);
    chk("tmo state", state, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vend_txn_ctrl.md
Name: vend_txn_ctrl

Overview:
- Parametrised successor to the current money-input / product-selector pair; one FSM owns the whole transaction.
- Flow: accept coins/notes, accumulate credit, validate a product selection against a writable price table, handshake the dispense, then pay out change one coin per handshake from a tracked coin inventory.
- Sits between the front-panel input logic and the dispenser/change-hopper drivers.

Parameters:
- CREDIT_W, 16, width of credit, prices and change arithmetic.
- NUM_PRODUCTS, 8, number of product slots (2..256).
- ADDR_W, 3, product address width; requires 2^ADDR_W >= NUM_PRODUCTS.
- CNT_W, 8, width of each per-denomination inventory counter.
- MAX_CREDIT, 20000, highest credit value the block accepts.
- TIMEOUT_CYCLES, 1000, idle cycles in COLLECT before auto-cancel (only with the optional feature).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- money_valid  in  1  money_type is presented this cycle.
- money_type  in  4  one-hot denomination: 0001=500, 0010=1000, 0100=2000, 1000=5000.
- money_ready  out  1  block can accept money this cycle.
- select_valid  in  1  select_addr is presented this cycle.
- select_addr  in  ADDR_W  requested product slot.
- select_ready  out  1  block can accept a selection this cycle.
- cancel  in  1  abort the transaction and refund credit.
- price_we  in  1  price table write strobe.
- price_waddr  in  ADDR_W  price table write address.
- price_wdata  in  CREDIT_W  price table write data.
- dispense_valid  out  1  dispense request.
- dispense_addr  out  ADDR_W  slot to dispense.
- dispense_ready  in  1  dispenser accepts the request.
- change_valid  out  1  change coin request.
- change_coin  out  4  one-hot coin to eject (same encoding as money_type).
- change_ready  in  1  hopper accepts the coin.
- credit  out  CREDIT_W  current credit.
- num_500, num_1000, num_2000, num_5000  out  CNT_W each  coin inventory counts.
- error  out  4  last error code.
- state  out  3  FSM state for debug.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE; credit, all num_*, error, dispense_valid, change_valid, change_coin and dispense_addr go to 0.
  - Price table reloads defaults: price[i]=500*(i+1).
- State encoding: IDLE=0, COLLECT=1, VEND=2, CHANGE=3.
- Handshakes: a transfer occurs when valid && ready on the same edge. Outputs are registered and update on the edge after acceptance.
- money_ready = state is IDLE or COLLECT, and cancel is low.
- select_ready = state is COLLECT, and money_valid and cancel are both low.
- Input priority: cancel > money > select.
- Money acceptance (IDLE/COLLECT), checked in this order:
  - money_type not one-hot -> error=1 (INVALID_MONEY); credit unchanged.
  - credit+value > MAX_CREDIT -> error=3 (OVERFLOW); money rejected.
  - Matching counter at all-ones -> error=6 (COIN_FULL); money rejected.
  - Otherwise: credit += value; matching num_* increments; error=0; state=COLLECT.
- Selection (COLLECT):
  - select_addr >= NUM_PRODUCTS -> error=5 (BAD_ADDR).
  - price > credit -> error=2 (INSUFFICIENT); state stays COLLECT.
  - Otherwise: credit -= price; dispense_addr=select_addr; dispense_valid=1; error=0; state=VEND.
- Price == credit is a valid purchase with zero change.
- VEND: hold dispense_valid and dispense_addr stable until dispense_ready. On the handshake, dispense_valid drops; next state is CHANGE if credit>0, else IDLE.
- CHANGE:
  - Select the largest denomination with value <= credit and inventory count > 0. Present it on change_coin with change_valid=1, held stable until change_ready.
  - On the handshake: credit -= value; that num_* decrements; re-evaluate next cycle. At most one coin per two cycles is acceptable.
  - credit==0 -> change_valid=0, state=IDLE.
  - credit>0 but no eligible coin -> error=4 (NO_CHANGE); remaining credit is kept; state=COLLECT so the customer can buy or add money.
- cancel: in COLLECT -> state=CHANGE with full credit. Ignored in IDLE, VEND and CHANGE.
- Price writes: applied only in IDLE; ignored in every other state with no error.
- Error persistence: error holds its value until the next accepted money or successful selection clears it.
- Reset mid-transaction: immediate return to reset values. Pending dispense/change requests are dropped and credit is lost (logged by the system, not this block).
- Arithmetic: all sums computed at CREDIT_W+1 bits before the MAX_CREDIT compare, so no wrap-around.

Optional Feature:
- Macro: VEND_TIMEOUT_EN.
- When defined: a counter of CREDIT_W bits reloads on any accepted money or selection and on entering COLLECT. When TIMEOUT_CYCLES cycles elapse in COLLECT with no accepted input, the block behaves exactly as cancel.
- When not defined: no counter is present; COLLECT is held indefinitely.

Test Plan:
- Reset low 2 cycles, then insert 500, 1000, 2000, 5000 -> credit=8500; each num_*=1; error=0; state=COLLECT.
- Credit 8500, select addr 3 (price 2000) with dispense_ready delayed 3 cycles -> dispense_valid held 3+ cycles, dispense_addr=3; change then ejects 5000, 1000, 500 (inventory-limited) -> credit=0, state=IDLE.
- Insert 1000, select addr 7 (price 4000) -> error=2, credit=1000. Then money_type=0110 -> error=1, credit=1000.
- From IDLE, write price[0]=1500; insert 2000; select 0 -> credit=500 after vend. Empty the 500 inventory first -> error=4, state=COLLECT, credit=500.
- Credit 18000, insert 5000 -> error=3, credit=18000. Assert cancel and money_valid in the same cycle -> cancel wins and refund starts.
- With VEND_TIMEOUT_EN and TIMEOUT_CYCLES=10: insert 500, then idle 10 cycles -> change_valid with change_coin=0001, then IDLE.
